// File: rtl/stair_lamp_ctrl_pkg.sv
// Shared definitions for the stairwell lamp sequencer: FSM state codes and
// counter-width helpers used to size timers from their cycle parameters.
package stair_lamp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_ON   = 2'd1,
        ST_WARN = 2'd2,
        ST_HOLD = 2'd3
    } lamp_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stair_lamp_ctrl_sw_debounce.sv
// Wall-switch front end: per-bit 2-FF synchroniser, parity of all switches,
// debounce of that parity, and a one-cycle pulse per accepted parity change.
module sw_debounce
    import stair_lamp_ctrl_pkg::*;
#(
    parameter int unsigned NSW     = 3,
    parameter int unsigned DEB_CYC = 500000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NSW-1:0] sw,
    output logic           trig
);

    localparam int unsigned     CW       = cnt_width(DEB_CYC);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);

    logic [NSW-1:0] sync1;
    logic [NSW-1:0] sync2;
    logic [1:0]     fill;
    logic           p;
    logic           cand;
    logic           cand_vld;
    logic           p_deb;
    logic           init_done;
    logic [CW-1:0]  cnt;

    assign p = ^sync2;

    // NOTE: every register here uses <= so all of them sample pre-edge values,
    // which is what makes sync1 -> sync2 a two-stage chain rather than one wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= '0;
            sync2     <= '0;
            fill      <= '0;
            cand      <= 1'b0;
            cand_vld  <= 1'b0;
            p_deb     <= 1'b0;
            init_done <= 1'b0;
            cnt       <= '0;
            trig      <= 1'b0;
        end else begin
            sync1 <= sw;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            trig  <= 1'b0;
            // Parity is meaningless until the synchroniser has filled after reset.
            if (!fill[1]) begin
                cand_vld <= 1'b0;
                cnt      <= '0;
            end else if (!cand_vld || (p != cand)) begin
                cand     <= p;
                cand_vld <= 1'b1;
                cnt      <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
            end else if (!init_done) begin
                // First settled level only seeds the reference; it is not a toggle.
                init_done <= 1'b1;
                p_deb     <= cand;
            end else if (p_deb != cand) begin
                p_deb <= cand;
                trig  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/stair_lamp_ctrl.sv
// Stairwell lamp sequencer: OFF -> ON -> WARN (blink + chirp) -> OFF, retriggered
// by any wall-switch toggle, with a maintenance hold. Lamp and buzzer active-low.
module stair_lamp_ctrl
    import stair_lamp_ctrl_pkg::*;
#(
    parameter int unsigned NSW        = 3,
    parameter int unsigned DEB_CYC    = 500000,
    parameter int unsigned ON_CYC     = 28'hFFFFFFF,
    parameter int unsigned WARN_CYC   = 50000000,
    parameter int unsigned BLINK_HALF = 12500000,
    parameter int unsigned BEEP_CYC   = 5000000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NSW-1:0] sw,
    input  logic           force_on,
    output logic           lamp_n,
    output logic           buzzer_n,
    output logic [1:0]     state,
    output logic           trig
);

    localparam int unsigned   TW          = cnt_width(max_u(ON_CYC, WARN_CYC));
    localparam logic [TW-1:0] ON_RELOAD   = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] WARN_RELOAD = TW'(WARN_CYC - 1);
    localparam int unsigned   BW          = cnt_width(BLINK_HALF);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);
    localparam int unsigned   EW          = cnt_width(BEEP_CYC + 1);
    localparam logic [EW-1:0] BEEP_LEN    = EW'(BEEP_CYC);

    lamp_state_t   cur_st;
    lamp_state_t   nxt_st;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nxt;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] blink_cnt_nxt;
    logic          blink_ph;
    logic          blink_ph_nxt;
    logic [EW-1:0] beep_cnt;
    logic [EW-1:0] beep_cnt_nxt;
    logic          lamp_on_nxt;
    logic          buzz_on_nxt;

    sw_debounce #(
        .NSW     (NSW),
        .DEB_CYC (DEB_CYC)
    ) u_sw_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (sw),
        .trig  (trig)
    );

    assign state = cur_st;

    // Drives are registered from the next-state values so they change on the
    // same edge as the state and have no combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st    <= ST_OFF;
            tmr       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            beep_cnt  <= '0;
            lamp_n    <= 1'b1;
            buzzer_n  <= 1'b1;
        end else begin
            cur_st    <= nxt_st;
            tmr       <= tmr_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_ph  <= blink_ph_nxt;
            beep_cnt  <= beep_cnt_nxt;
            lamp_n    <= ~lamp_on_nxt;
            buzzer_n  <= ~buzz_on_nxt;
        end
    end

    // NOTE: both outputs get a default before the case so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_st  = cur_st;
        tmr_nxt = tmr;
        if (force_on) begin
            nxt_st = ST_HOLD;
        end else begin
            unique case (cur_st)
                ST_OFF: begin
                    if (trig) begin
                        nxt_st  = ST_ON;
                        tmr_nxt = ON_RELOAD;
                    end
                end
                ST_ON: begin
                    if (trig) begin
                        tmr_nxt = ON_RELOAD;
                    end else if (tmr == '0) begin
                        nxt_st  = ST_WARN;
                        tmr_nxt = WARN_RELOAD;
                    end else begin
                        tmr_nxt = tmr - TW'(1);
                    end
                end
                ST_WARN: begin
                    if (trig) begin
                        nxt_st  = ST_ON;
                        tmr_nxt = ON_RELOAD;
                    end else if (tmr == '0) begin
                        nxt_st = ST_OFF;
                    end else begin
                        tmr_nxt = tmr - TW'(1);
                    end
                end
                ST_HOLD: begin
                    // Leaving maintenance always restarts a full on period; trig is dropped.
                    nxt_st  = ST_ON;
                    tmr_nxt = ON_RELOAD;
                end
                default: nxt_st = ST_OFF;
            endcase
        end
    end

    always_comb begin
        blink_cnt_nxt = '0;
        blink_ph_nxt  = 1'b0;
        beep_cnt_nxt  = '0;
        if ((nxt_st == ST_WARN) && (cur_st == ST_WARN)) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_ph_nxt = ~blink_ph;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
                blink_ph_nxt  = blink_ph;
            end
            beep_cnt_nxt = (beep_cnt == BEEP_LEN) ? beep_cnt : beep_cnt + EW'(1);
        end
        lamp_on_nxt = (nxt_st == ST_ON) || (nxt_st == ST_HOLD) ||
                      ((nxt_st == ST_WARN) && !blink_ph_nxt);
        buzz_on_nxt = (nxt_st == ST_WARN) && (beep_cnt_nxt < BEEP_LEN);
    end

endmodule
